tdm_demux4: RTL and testbench
=============================

Name: tdm_demux4

Overview:
- Receive end of a 4-slot time-division link: the transmit side time-multiplexes four lanes onto one word stream, one lane per slot.
- This block locks to the frame-sync marker and steers each received word into its slot register.
- Once slot 3 lands, it presents all four lanes as one parallel frame with a single-cycle frame_valid strobe.
- Sits between the serial link front end and the per-lane consumers.

Parameters:
- W, 8, data width of one slot word and of each output lane.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- din  input  W  slot word from the link.
- din_valid  input  1  din carries a word this cycle; no word is consumed when low.
- frame_sync  input  1  qualified by din_valid; marks din as slot 0 of a frame.
- dout  output  4*W  parallel frame; lane k occupies bits [k*W +: W].
- frame_valid  output  1  one-cycle pulse; dout holds a new complete frame.
- locked  output  1  high while the FSM is in LOCKED.
- slot  output  2  index the next accepted word will be written to.
- sync_err  output  1  one-cycle pulse on any framing violation.

Behaviour:
- Reset (asynchronous, active-high): dout=0, frame_valid=0, sync_err=0, locked=0, slot=0, shadow registers=0, state=HUNT. Assertion mid-frame discards the partial frame immediately.
- State HUNT:
  - Words without frame_sync are dropped.
  - On din_valid&frame_sync: write shadow[0]=din, slot<=1, go to LOCKED.
- State LOCKED, each din_valid cycle:
  - Normal case: write shadow[slot]=din, then slot<=slot+1 modulo 4 (3 wraps to 0).
- Frame completion:
  - On the edge that accepts the slot-3 word: dout<={din,shadow[2],shadow[1],shadow[0]} and frame_valid=1 for exactly that cycle.
  - Latency from slot-3 word to dout/frame_valid is one clock.
  - dout holds its value until the next completed frame.
- Early sync: frame_sync asserted in LOCKED with slot!=0:
  - sync_err pulses for one cycle and the partial frame is discarded.
  - din is taken as the new slot 0: shadow[0]=din, slot<=1, state stays LOCKED.
  - dout and frame_valid are not updated.
- Missing sync: slot==0 in LOCKED with din_valid and no frame_sync is handled per the Optional Feature.
- din_valid low: no state change, frame_sync ignored, slot holds. Gaps between words of any length are legal.
- Back-to-back frames: din_valid held high with sync every 4th word gives a frame_valid pulse every 4 cycles, with no bubble.
- Only one event is processed per cycle. Early-sync priority over completion is not reachable, because slot 3 with sync is the early-sync case.
- Outputs are fully registered; there is no combinational path from inputs to outputs.

Optional Feature:
- Macro: TDM_DEMUX_FLYWHEEL_EN.
- Defined: a missing frame_sync at slot 0 in LOCKED is tolerated. The word is accepted as slot 0 (flywheel), with no sync_err and the state kept.
- Undefined: a missing frame_sync at slot 0 pulses sync_err, drops the word, sets slot<=0 and returns to HUNT (locked falls on the same edge).

Test Plan:
1. Reset, then din_valid=1 continuously with din=0x11,0x22,0x33,0x44 and sync on 0x11 -> one cycle after 0x44: dout=0x44332211, frame_valid pulses once, locked=1.
2. Words 0xAA,0xBB without sync in HUNT, then framed 0x01..0x04 -> 0xAA/0xBB ignored, dout=0x04030201, sync_err never asserted.
3. Framed 0x10,0x20 then sync on 0x30, followed by 0x40,0x50,0x60 -> sync_err one pulse on the 0x30 edge, no frame_valid for the partial frame, then dout=0x60504030.
4. Gapped input 0xA1, idle 3 cycles, 0xA2, idle, 0xA3, 0xA4 with sync on 0xA1 -> slot holds during gaps, single frame_valid, dout=0xA4A3A2A1.
5. Locked with slot=2, assert rst asynchronously mid-cycle -> outputs clear immediately, locked=0, slot=0, and the next framed 0x01..0x04 yields dout=0x04030201.
6. After a full frame, send 0x55 with no sync (macro undefined) -> sync_err pulse, locked=0. With TDM_DEMUX_FLYWHEEL_EN defined, 0x55,0x66,0x77,0x88 -> dout=0x88776655 and no sync_err.

Source files
------------

// File: rtl/tdm_demux4.sv
// 4-slot TDM receive demultiplexer: locks to frame_sync, gathers slots 0..3, emits a parallel frame.
// Optional build macro TDM_DEMUX_FLYWHEEL_EN: tolerate a missing sync at slot 0 while locked.
module tdm_demux4 #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [W-1:0]   din,
    input  logic           din_valid,
    input  logic           frame_sync,
    output logic [4*W-1:0] dout,
    output logic           frame_valid,
    output logic           locked,
    output logic [1:0]     slot,
    output logic           sync_err
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     slot_q, slot_d;
    logic [W-1:0]   shadow_q [3];
    logic [W-1:0]   shadow_d [3];
    logic [4*W-1:0] dout_q, dout_d;
    logic           frame_valid_q, frame_valid_d;
    logic           sync_err_q, sync_err_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= HUNT;
            slot_q        <= 2'd0;
            shadow_q[0]   <= '0;
            shadow_q[1]   <= '0;
            shadow_q[2]   <= '0;
            dout_q        <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            shadow_q      <= shadow_d;
            dout_q        <= dout_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        shadow_d      = shadow_q;
        dout_d        = dout_q;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;

        if (din_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (frame_sync) begin
                        shadow_d[0] = din;
                        slot_d      = 2'd1;
                        state_d     = LOCKED;
                    end
                end
                LOCKED: begin
                    if (frame_sync && slot_q != 2'd0) begin
                        // Early sync: restart the frame on this word.
                        sync_err_d  = 1'b1;
                        shadow_d[0] = din;
                        slot_d      = 2'd1;
                    end else if (!frame_sync && slot_q == 2'd0) begin
`ifdef TDM_DEMUX_FLYWHEEL_EN
                        shadow_d[0] = din;
                        slot_d      = 2'd1;
`else
                        sync_err_d  = 1'b1;
                        slot_d      = 2'd0;
                        state_d     = HUNT;
`endif
                    end else begin
                        unique case (slot_q)
                            2'd0: begin
                                shadow_d[0] = din;
                                slot_d      = 2'd1;
                            end
                            2'd1: begin
                                shadow_d[1] = din;
                                slot_d      = 2'd2;
                            end
                            2'd2: begin
                                shadow_d[2] = din;
                                slot_d      = 2'd3;
                            end
                            default: begin
                                // Slot 3 goes straight to dout; no shadow needed.
                                dout_d        = {din, shadow_q[2], shadow_q[1], shadow_q[0]};
                                frame_valid_d = 1'b1;
                                slot_d        = 2'd0;
                            end
                        endcase
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    assign dout        = dout_q;
    assign frame_valid = frame_valid_q;
    assign sync_err    = sync_err_q;
    assign locked      = (state_q == LOCKED);
    assign slot        = slot_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Scoreboard bench for tdm_demux4: stimulus queues expected frames/errors, a monitor checks them.
module tb_tdm_demux4;

    localparam int W = 8;

    logic           clk;
    logic           rst;
    logic [W-1:0]   din;
    logic           din_valid;
    logic           frame_sync;
    logic [4*W-1:0] dout;
    logic           frame_valid;
    logic           locked;
    logic [1:0]     slot;
    logic           sync_err;

    typedef struct {
        bit          is_err;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    tdm_demux4 #(.W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .frame_sync  (frame_sync),
        .dout        (dout),
        .frame_valid (frame_valid),
        .locked      (locked),
        .slot        (slot),
        .sync_err    (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    task automatic word(input logic [7:0] d, input logic s);
        @(negedge clk);
        din        = d;
        din_valid  = 1'b1;
        frame_sync = s;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            din_valid  = 1'b0;
            frame_sync = 1'b0;
            din        = 8'hXX;
        end
    endtask

    task automatic push_frame(input logic [31:0] f);
        exp_t e;
        e.is_err = 1'b0;
        e.data   = f;
        exp_q.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        e.is_err = 1'b1;
        e.data   = '0;
        exp_q.push_back(e);
    endtask

    task automatic frame4(input logic [7:0] a, b, c, d);
        word(a, 1'b1);
        word(b, 1'b0);
        word(c, 1'b0);
        push_frame({d, c, b, a});
        word(d, 1'b0);
    endtask

    // Monitor: every output event must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frame_valid", dout, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("frame_kind", {31'd0, e.is_err}, 32'd0);
                    check("frame_dout", dout, e.data);
                end
            end
            if (sync_err) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_sync_err", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sync_err_kind", {31'd0, e.is_err}, 32'd1);
                end
            end
        end
    end

    initial begin
        rst        = 1'b1;
        din        = '0;
        din_valid  = 1'b0;
        frame_sync = 1'b0;
        #1;
        check("reset_dout", dout, 32'h0);
        check("reset_flags", {28'd0, frame_valid, sync_err, locked, 1'b0}, 32'h0);
        check("reset_slot", {30'd0, slot}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 1: single frame, then two back-to-back frames with no bubble
        frame4(8'h11, 8'h22, 8'h33, 8'h44);
        frame4(8'hC1, 8'hC2, 8'hC3, 8'hC4);
        frame4(8'hD1, 8'hD2, 8'hD3, 8'hD4);
        idle(2);
        check("t1_locked", {31'd0, locked}, 32'd1);

        // 2: unsynced words in HUNT are dropped
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        word(8'hAA, 1'b0);
        word(8'hBB, 1'b0);
        idle(1);
        check("t2_hunt_unlocked", {31'd0, locked}, 32'd0);
        check("t2_hunt_slot", {30'd0, slot}, 32'd0);
        frame4(8'h01, 8'h02, 8'h03, 8'h04);

        // 3: early sync at slot 2
        word(8'h10, 1'b1);
        word(8'h20, 1'b0);
        push_err();
        word(8'h30, 1'b1);
        word(8'h40, 1'b0);
        word(8'h50, 1'b0);
        push_frame(32'h60504030);
        word(8'h60, 1'b0);
        idle(2);

        // 4: gaps between words hold the slot
        word(8'hA1, 1'b1);
        idle(3);
        check("t4_gap_slot1", {30'd0, slot}, 32'd1);
        word(8'hA2, 1'b0);
        idle(1);
        check("t4_gap_slot2", {30'd0, slot}, 32'd2);
        word(8'hA3, 1'b0);
        push_frame(32'hA4A3A2A1);
        word(8'hA4, 1'b0);
        idle(2);

        // 5: asynchronous reset mid-frame
        word(8'h01, 1'b1);
        word(8'h02, 1'b0);
        idle(1);
        check("t5_pre_slot", {30'd0, slot}, 32'd2);
        check("t5_pre_dout", dout, 32'hA4A3A2A1);
        #2;
        rst = 1'b1;
        #1;
        check("t5_rst_dout", dout, 32'h0);
        check("t5_rst_locked", {31'd0, locked}, 32'd0);
        check("t5_rst_slot", {30'd0, slot}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        frame4(8'h01, 8'h02, 8'h03, 8'h04);
        idle(2);

        // 6: missing sync at slot 0 after a full frame
`ifdef TDM_DEMUX_FLYWHEEL_EN
        word(8'h55, 1'b0);
        word(8'h66, 1'b0);
        word(8'h77, 1'b0);
        push_frame(32'h88776655);
        word(8'h88, 1'b0);
        idle(2);
        check("t6_fly_locked", {31'd0, locked}, 32'd1);
`else
        push_err();
        word(8'h55, 1'b0);
        idle(2);
        check("t6_unlocked", {31'd0, locked}, 32'd0);
        check("t6_slot", {30'd0, slot}, 32'd0);
        check("t6_dout_kept", dout, 32'h04030201);
`endif

        idle(3);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
